// File: rtl/if_id_stage_reg_pkg.sv
// Shared IF/ID definitions: datapath and counter widths, the NOP word, and the
// per-edge slot operation chosen by the rst > flush > freeze > load priority.
package if_id_stage_reg_pkg;

    localparam int          BIT_NUMBER_DEF = 32;
    localparam int          CNT_WIDTH_DEF  = 16;
    localparam logic [31:0] NOP_WORD_DEF   = 32'd0;

    typedef enum logic [1:0] {
        SLOT_RESET = 2'd0,
        SLOT_FLUSH = 2'd1,
        SLOT_HOLD  = 2'd2,
        SLOT_LOAD  = 2'd3
    } slot_op_e;

    function automatic slot_op_e slot_op(input logic rst, input logic flush, input logic freeze);
        slot_op_e op;
        if (rst) begin
            op = SLOT_RESET;
        end else if (flush) begin
            op = SLOT_FLUSH;
        end else if (freeze) begin
            op = SLOT_HOLD;
        end else begin
            op = SLOT_LOAD;
        end
        return op;
    endfunction

endpackage

// File: rtl/if_id_stage_reg_sat_counter.sv
// Saturating up-counter with synchronous active-high reset; sticks at all-ones.
module sat_counter #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    output logic [WIDTH-1:0] count
);

    localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

    logic [WIDTH-1:0] r_count;

    // count register: clear on reset, increment unless already saturated
    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
        end else if (inc && (r_count != '1)) begin
            r_count <= r_count + ONE;
        end else begin
            r_count <= r_count;
        end
    end

    assign count = r_count;

endmodule

// File: rtl/if_id_stage_reg.sv
// IF->ID pipeline register with freeze, flush-to-bubble, valid tracking and
// saturating fetch/flush/stall performance counters.
module if_id_stage_reg
    import if_id_stage_reg_pkg::*;
#(
    parameter int                    BIT_NUMBER = BIT_NUMBER_DEF,
    parameter int                    CNT_WIDTH  = CNT_WIDTH_DEF,
    parameter logic [BIT_NUMBER-1:0] NOP_WORD   = BIT_NUMBER'(NOP_WORD_DEF)
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  freeze,
    input  logic                  flush,
    input  logic [BIT_NUMBER-1:0] pc_in,
    input  logic [BIT_NUMBER-1:0] instruction_in,
    output logic [BIT_NUMBER-1:0] pc,
    output logic [BIT_NUMBER-1:0] instruction,
    output logic                  valid,
    output logic [CNT_WIDTH-1:0]  fetch_count,
    output logic [CNT_WIDTH-1:0]  flush_count,
    output logic [CNT_WIDTH-1:0]  stall_count
);

    slot_op_e              w_op;
    logic [BIT_NUMBER-1:0] w_pc_next;
    logic [BIT_NUMBER-1:0] w_ins_next;
    logic                  w_valid_next;
    logic [BIT_NUMBER-1:0] r_pc;
    logic [BIT_NUMBER-1:0] r_ins;
    logic                  r_valid;

    assign w_op = slot_op(rst, flush, freeze);

    // next-slot mux; pc_in/instruction_in are only selected on a plain load,
    // so unknown inputs during flush or freeze never reach the register
    always_comb begin
        w_pc_next    = r_pc;
        w_ins_next   = r_ins;
        w_valid_next = r_valid;
        case (w_op)
            SLOT_RESET, SLOT_FLUSH: begin
                w_pc_next    = '0;
                w_ins_next   = NOP_WORD;
                w_valid_next = 1'b0;
            end
            SLOT_HOLD: begin
                w_pc_next    = r_pc;
                w_ins_next   = r_ins;
                w_valid_next = r_valid;
            end
            SLOT_LOAD: begin
                w_pc_next    = pc_in;
                w_ins_next   = instruction_in;
                w_valid_next = 1'b1;
            end
            default: begin
                w_pc_next    = '0;
                w_ins_next   = NOP_WORD;
                w_valid_next = 1'b0;
            end
        endcase
    end

    // slot register; reset is folded into the next-state mux above
    always_ff @(posedge clk) begin
        r_pc    <= w_pc_next;
        r_ins   <= w_ins_next;
        r_valid <= w_valid_next;
    end

    assign pc          = r_pc;
    assign instruction = r_ins;
    assign valid       = r_valid;

    sat_counter #(.WIDTH(CNT_WIDTH)) u_fetch_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_op == SLOT_LOAD),
        .count (fetch_count)
    );

    sat_counter #(.WIDTH(CNT_WIDTH)) u_flush_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   (w_op == SLOT_FLUSH),
        .count (flush_count)
    );

    // a frozen bubble is not a stall worth counting
    sat_counter #(.WIDTH(CNT_WIDTH)) u_stall_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc   ((w_op == SLOT_HOLD) && r_valid),
        .count (stall_count)
    );

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: directed vector table, random stimulus against a
// behavioural model, and a counter saturation run on a 4-bit-counter copy.
module tb_if_id_stage_reg;

    localparam logic [31:0] NOP = 32'd0;

    logic        clk;
    logic        rst;
    logic        freeze;
    logic        flush;
    logic [31:0] pc_in;
    logic [31:0] instruction_in;

    logic [31:0] pc, instruction;
    logic        valid;
    logic [15:0] fetch_count, flush_count, stall_count;

    logic [31:0] s_pc, s_instruction;
    logic        s_valid;
    logic [3:0]  s_fetch_count, s_flush_count, s_stall_count;

    int checks   = 0;
    int failures = 0;

    // model state: slot contents plus unbounded event counts since reset
    logic [31:0] m_pc, m_ins;
    logic        m_valid;
    int          m_fetch, m_flush, m_stall;

    typedef struct {
        logic        rst;
        logic        flush;
        logic        freeze;
        logic [31:0] pc_in;
        logic [31:0] ins_in;
        logic [31:0] e_pc;
        logic [31:0] e_ins;
        logic        e_valid;
        int          e_fetch;
        int          e_flush;
        int          e_stall;
    } vec_t;

    vec_t vecs[14];

    if_id_stage_reg dut (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .pc(pc), .instruction(instruction), .valid(valid),
        .fetch_count(fetch_count), .flush_count(flush_count), .stall_count(stall_count)
    );

    if_id_stage_reg #(.CNT_WIDTH(4)) dut_small (
        .clk(clk), .rst(rst), .freeze(freeze), .flush(flush),
        .pc_in(pc_in), .instruction_in(instruction_in),
        .pc(s_pc), .instruction(s_instruction), .valid(s_valid),
        .fetch_count(s_fetch_count), .flush_count(s_flush_count), .stall_count(s_stall_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    function automatic int sat(input int v, input int maxv);
        return (v > maxv) ? maxv : v;
    endfunction

    // apply one cycle's inputs, clock it, then advance the model
    task automatic step(input logic r, input logic fl, input logic fz,
                        input logic [31:0] p, input logic [31:0] i);
        rst = r; flush = fl; freeze = fz; pc_in = p; instruction_in = i;
        @(posedge clk);
        #1;
        if (r) begin
            m_pc = 32'd0; m_ins = NOP; m_valid = 1'b0;
            m_fetch = 0; m_flush = 0; m_stall = 0;
        end else if (fl) begin
            m_pc = 32'd0; m_ins = NOP; m_valid = 1'b0;
            m_flush++;
        end else if (fz) begin
            if (m_valid) m_stall++;
        end else begin
            m_pc = p; m_ins = i; m_valid = 1'b1;
            m_fetch++;
        end
    endtask

    task automatic chk_model(input string tag);
        chk({tag, ".pc"},    pc, m_pc);
        chk({tag, ".ins"},   instruction, m_ins);
        chk({tag, ".valid"}, {31'd0, valid}, {31'd0, m_valid});
        chk({tag, ".fetch"}, {16'd0, fetch_count}, sat(m_fetch, 65535));
        chk({tag, ".flush"}, {16'd0, flush_count}, sat(m_flush, 65535));
        chk({tag, ".stall"}, {16'd0, stall_count}, sat(m_stall, 65535));
        chk({tag, ".s_fetch"}, {28'd0, s_fetch_count}, sat(m_fetch, 15));
        chk({tag, ".s_flush"}, {28'd0, s_flush_count}, sat(m_flush, 15));
        chk({tag, ".s_stall"}, {28'd0, s_stall_count}, sat(m_stall, 15));
    endtask

    initial begin
        rst = 1'b1; flush = 1'b0; freeze = 1'b0; pc_in = 32'd0; instruction_in = 32'd0;
        m_pc = 32'd0; m_ins = NOP; m_valid = 1'b0; m_fetch = 0; m_flush = 0; m_stall = 0;

        //         rst   flush freeze pc_in   ins_in        e_pc    e_ins         v   fe fl st
        vecs[0]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'h0,        32'd0,  NOP,          1'b0, 0, 0, 0};
        vecs[1]  = '{1'b1, 1'b0, 1'b0, 32'd0,  32'h0,        32'd0,  NOP,          1'b0, 0, 0, 0};
        vecs[2]  = '{1'b0, 1'b0, 1'b0, 32'd4,  32'hE3A01005, 32'd4,  32'hE3A01005, 1'b1, 1, 0, 0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 32'd8,  32'hE2811001, 32'd8,  32'hE2811001, 1'b1, 2, 0, 0};
        vecs[4]  = '{1'b0, 1'b0, 1'b1, 32'd12, 32'hDEADBEEF, 32'd8,  32'hE2811001, 1'b1, 2, 0, 1};
        vecs[5]  = '{1'b0, 1'b0, 1'b1, 32'd12, 32'hDEADBEEF, 32'd8,  32'hE2811001, 1'b1, 2, 0, 2};
        vecs[6]  = '{1'b0, 1'b0, 1'b1, 32'd12, 32'hDEADBEEF, 32'd8,  32'hE2811001, 1'b1, 2, 0, 3};
        vecs[7]  = '{1'b0, 1'b1, 1'b1, 32'd12, 32'hDEADBEEF, 32'd0,  NOP,          1'b0, 2, 1, 3};
        vecs[8]  = '{1'b0, 1'b0, 1'b1, 32'd20, 32'h12345678, 32'd0,  NOP,          1'b0, 2, 1, 3};
        vecs[9]  = '{1'b0, 1'b0, 1'b1, 32'd24, 32'h12345678, 32'd0,  NOP,          1'b0, 2, 1, 3};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 32'd16, 32'hE0812003, 32'd16, 32'hE0812003, 1'b1, 3, 1, 3};
        vecs[11] = '{1'b0, 1'b0, 1'b1, 32'd28, 32'hCAFEF00D, 32'd16, 32'hE0812003, 1'b1, 3, 1, 4};
        vecs[12] = '{1'b1, 1'b0, 1'b1, 32'd32, 32'hCAFEF00D, 32'd0,  NOP,          1'b0, 0, 0, 0};
        vecs[13] = '{1'b0, 1'b1, 1'b0, 32'd36, 32'hAAAA5555, 32'd0,  NOP,          1'b0, 0, 1, 0};

        for (int k = 0; k < 14; k++) begin
            step(vecs[k].rst, vecs[k].flush, vecs[k].freeze, vecs[k].pc_in, vecs[k].ins_in);
            chk($sformatf("vec%0d.pc", k),    pc, vecs[k].e_pc);
            chk($sformatf("vec%0d.ins", k),   instruction, vecs[k].e_ins);
            chk($sformatf("vec%0d.valid", k), {31'd0, valid}, {31'd0, vecs[k].e_valid});
            chk($sformatf("vec%0d.fetch", k), {16'd0, fetch_count}, vecs[k].e_fetch);
            chk($sformatf("vec%0d.flush", k), {16'd0, flush_count}, vecs[k].e_flush);
            chk($sformatf("vec%0d.stall", k), {16'd0, stall_count}, vecs[k].e_stall);
        end

        // saturation: 20 back-to-back loads after reset
        step(1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        for (int k = 0; k < 20; k++) begin
            step(1'b0, 1'b0, 1'b0, 32'd4 * (k + 1), 32'hE1A00000 + k);
            if (k >= 14) chk($sformatf("sat%0d.s_fetch", k), {28'd0, s_fetch_count}, 32'd15);
        end
        chk("sat.fetch16", {16'd0, fetch_count}, 32'd20);
        chk("sat.pc", pc, 32'd80);
        chk("sat.ins", instruction, 32'hE1A00013);

        // randomized traffic against the model
        for (int k = 0; k < 400; k++) begin
            step(($urandom_range(0, 39) == 0), ($urandom_range(0, 5) == 0),
                 ($urandom_range(0, 2) == 0), $urandom, $urandom);
            chk_model($sformatf("rnd%0d", k));
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
